// File: rtl/fw_msg_collector.sv
// fw_msg_collector: collects NUL-terminated firmware strings and delivers them as messages on a valid/ready port.
// Define FW_MSG_TIMESTAMP_EN to stamp each message with a free-running cycle count.
module fw_msg_collector #(
  parameter int MAX_CHARS = 32,
  parameter int IDX_W     = 6,
  parameter int KINDS     = 4,
  parameter int DATA_W    = 32
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_n_i,
  input  logic                   write_mem,
  input  logic [IDX_W-1:0]       index,
  input  logic [7:0]             data,
  input  logic [KINDS-1:0]       evt_i,
  input  logic [DATA_W-1:0]      expected_i,
  input  logic [DATA_W-1:0]      measured_i,
  output logic                   msg_valid_o,
  input  logic                   msg_ready_i,
  output logic [8*MAX_CHARS-1:0] msg_text_o,
  output logic [IDX_W-1:0]       msg_len_o,
  output logic [KINDS-1:0]       msg_kind_o,
  output logic [DATA_W-1:0]      msg_expected_o,
  output logic [DATA_W-1:0]      msg_measured_o,
  output logic [31:0]            msg_time_o,
  output logic                   busy_o,
  output logic                   overflow_o,
  output logic [7:0]             dropped_cnt_o
);
  localparam int AW = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
  state_t           state;
  logic [7:0]       mem [MAX_CHARS];
  logic [KINDS-1:0] evt_q, pending, rise, sel;
  logic [IDX_W-1:0] ptr;
  logic [7:0]       cur;
  logic             scan_end, wr_ok, wr_next;
  logic [8:0]       drop_sum;
  logic [31:0]      ts;
  assign rise     = evt_i & ~evt_q;
  // lowest pending bit wins; only consumed while idle
  assign sel      = (state == IDLE) ? pending & (~pending + KINDS'(1)) : '0;
  assign cur      = (int'(ptr) < MAX_CHARS) ? mem[ptr[AW-1:0]] : 8'h00;
  assign scan_end = cur == 8'h00;
  assign wr_ok    = write_mem && int'(index) < MAX_CHARS;
  assign wr_next  = wr_ok && int'(index) + 1 < MAX_CHARS;
  assign drop_sum = {1'b0, dropped_cnt_o} + 9'($countones(rise & pending));
  assign busy_o   = state != IDLE;
`ifdef FW_MSG_TIMESTAMP_EN
  logic [31:0] cyc_cnt;
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
    if (!wb_rst_n_i) cyc_cnt <= '0;
    else cyc_cnt <= cyc_cnt + 32'd1;
  assign ts = cyc_cnt;
`else
  assign ts = '0;
`endif
  // firmware write comes last so it overrides a same-cycle scan clear
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
    if (!wb_rst_n_i) begin
      for (int i = 0; i < MAX_CHARS; i++) mem[i] <= '0;
    end else begin
      if (state == SCAN && !scan_end) mem[ptr[AW-1:0]] <= '0;
      if (wr_next) mem[index[AW-1:0] + AW'(1)] <= '0;
      if (wr_ok) mem[index[AW-1:0]] <= data;
    end
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
    if (!wb_rst_n_i) begin
      evt_q         <= '0;
      pending       <= '0;
      dropped_cnt_o <= '0;
      overflow_o    <= 1'b0;
    end else begin
      evt_q         <= evt_i;
      pending       <= (pending & ~sel) | rise;
      dropped_cnt_o <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      if (write_mem && !wr_ok) overflow_o <= 1'b1;
    end
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
    if (!wb_rst_n_i) begin
      state          <= IDLE;
      ptr            <= '0;
      msg_valid_o    <= 1'b0;
      msg_text_o     <= '0;
      msg_len_o      <= '0;
      msg_kind_o     <= '0;
      msg_expected_o <= '0;
      msg_measured_o <= '0;
      msg_time_o     <= '0;
    end else begin
      case (state)
        IDLE: if (|pending) begin
          msg_kind_o     <= sel;
          msg_expected_o <= expected_i;
          msg_measured_o <= measured_i;
          msg_time_o     <= ts;
          msg_text_o     <= '0;
          ptr            <= '0;
          state          <= SCAN;
        end
        SCAN: if (scan_end) begin
          msg_len_o   <= ptr;
          msg_valid_o <= 1'b1;
          state       <= HOLD;
        end else begin
          msg_text_o <= {msg_text_o[8*MAX_CHARS-9:0], cur};
          ptr        <= ptr + IDX_W'(1);
        end
        HOLD: if (msg_ready_i) begin
          msg_valid_o <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fw_msg_collector.sv
// tb_fw_msg_collector: directed plus randomized checks of fw_msg_collector against a string-level reference model.
module tb_fw_msg_collector;
  localparam int MC = 32, IW = 6, K = 4, DW = 32;
  logic clk = 1'b0, rst_n = 1'b0, write_mem = 1'b0, msg_ready_i = 1'b0;
  logic [IW-1:0] index = '0;
  logic [7:0] data = '0;
  logic [K-1:0] evt_i = '0;
  logic [DW-1:0] expected_i = '0, measured_i = '0;
  logic msg_valid_o, busy_o, overflow_o;
  logic [8*MC-1:0] msg_text_o;
  logic [IW-1:0] msg_len_o;
  logic [K-1:0] msg_kind_o;
  logic [DW-1:0] msg_expected_o, msg_measured_o;
  logic [31:0] msg_time_o;
  logic [7:0] dropped_cnt_o;
  int n_cmp = 0, n_err = 0;
  logic [7:0] mmem [MC];
  logic [K-1:0] mpend = '0;
  int mdrop = 0;
  logic movf = 1'b0;
  logic [31:0] cyc;

  fw_msg_collector #(.MAX_CHARS(MC), .IDX_W(IW), .KINDS(K), .DATA_W(DW)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .write_mem(write_mem), .index(index), .data(data),
    .evt_i(evt_i), .expected_i(expected_i), .measured_i(measured_i),
    .msg_valid_o(msg_valid_o), .msg_ready_i(msg_ready_i), .msg_text_o(msg_text_o),
    .msg_len_o(msg_len_o), .msg_kind_o(msg_kind_o), .msg_expected_o(msg_expected_o),
    .msg_measured_o(msg_measured_o), .msg_time_o(msg_time_o), .busy_o(busy_o),
    .overflow_o(overflow_o), .dropped_cnt_o(dropped_cnt_o));

  always #5 clk = ~clk;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= '0;
    else cyc <= cyc + 32'd1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input string tag);
    logic [255:0] o, e;
    for (int i = 0; i < MC; i++) begin
      o[i*8 +: 8] = dut.mem[i];
      e[i*8 +: 8] = mmem[i];
    end
    chk(tag, o, e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < MC; i++) mmem[i] = 8'h00;
    mpend = '0;
    mdrop = 0;
    movf = 1'b0;
  endtask

  task automatic wr(input int idx, input logic [7:0] d);
    write_mem = 1'b1;
    index = IW'(idx);
    data = d;
    if (idx < MC) begin
      mmem[idx] = d;
      if (idx + 1 < MC) mmem[idx+1] = 8'h00;
    end else movf = 1'b1;
    @(negedge clk);
    write_mem = 1'b0;
  endtask

  task automatic pulse(input logic [K-1:0] m, output logic [31:0] t);
    t = cyc + 32'd1;
    evt_i = m;
    for (int k = 0; k < K; k++)
      if (m[k]) begin
        if (mpend[k]) mdrop = (mdrop == 255) ? 255 : mdrop + 1;
        mpend[k] = 1'b1;
      end
    @(negedge clk);
    evt_i = '0;
  endtask

  task automatic wait_valid(input int lim, output int n);
    n = 0;
    while (!msg_valid_o && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("valid_timeout", msg_valid_o, 1);
  endtask

  task automatic expect_msg(input logic first, input logic [31:0] t);
    int n, len, k;
    logic [255:0] txt;
    wait_valid(200, n);
    k = 0;
    while (k < K - 1 && !mpend[k]) k++;
    mpend[k] = 1'b0;
    len = 0;
    txt = '0;
    while (len < MC && mmem[len] != 8'h00) begin
      txt = {txt[247:0], mmem[len]};
      mmem[len] = 8'h00;
      len++;
    end
    if (first) chk("latency", n, len + 2);
    chk("kind", msg_kind_o, 320'(1) << k);
    chk("len", msg_len_o, len);
    chk("text", msg_text_o, txt);
    chk("expected", msg_expected_o, expected_i);
    chk("measured", msg_measured_o, measured_i);
`ifdef FW_MSG_TIMESTAMP_EN
    if (first) chk("time", msg_time_o, t);
`else
    chk("time", msg_time_o, 0);
`endif
  endtask

  task automatic ack(input int dly);
    repeat (dly) @(negedge clk);
    msg_ready_i = 1'b1;
    @(negedge clk);
    msg_ready_i = 1'b0;
    chk("valid_drop", msg_valid_o, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {msg_valid_o, msg_len_o, msg_kind_o, msg_expected_o, msg_measured_o, msg_time_o,
              busy_o, overflow_o, dropped_cnt_o}, 0);
    chk({tag, "_text"}, msg_text_o, 0);
  endtask

  initial begin
    logic [31:0] t;
    logic [319:0] snap;
    int len, seen;
    logic [K-1:0] m;
    model_reset();
    repeat (2) @(negedge clk);
    chk_zero("reset");
    chk_mem("reset_mem");
    rst_n = 1'b1;
    @(negedge clk);

    // "PASS" as a report
    wr(0, "P"); wr(1, "A"); wr(2, "S"); wr(3, "S");
    pulse(4'b0001, t);
    expect_msg(1'b1, t);
    chk("pass_text_lsw", msg_text_o[31:0], 32'h50415353);
    ack(0);
    chk_mem("pass_cleared");

    // simultaneous report and error: report first, error empty
    wr(0, "A"); wr(1, "B");
    pulse(4'b0101, t);
    expect_msg(1'b1, t);
    chk("ab_text", msg_text_o, 16'h4142);
    ack(1);
    expect_msg(1'b0, t);
    chk("err_len", msg_len_o, 0);
    ack(0);

    // full buffer, no NUL, compare event
    for (int i = 0; i < MC; i++) wr(i, 8'(8'h30 + i));
    expected_i = 32'h12345678;
    measured_i = 32'h12345679;
    pulse(4'b1000, t);
    expect_msg(1'b1, t);
    chk("full_len", msg_len_o, MC);
    ack(2);
    chk_mem("full_cleared");

    // back-pressure: outputs stable, re-raises counted as drops
    wr(0, "W");
    pulse(4'b0010, t);
    expect_msg(1'b1, t);
    snap = {msg_text_o, msg_expected_o, msg_valid_o, msg_len_o, msg_kind_o};
    for (int i = 0; i < 10; i++) begin
      if (i == 2 || i == 6) begin
        pulse(4'b0010, t);
      end else @(negedge clk);
      chk("hold_stable", {msg_text_o, msg_expected_o, msg_valid_o, msg_len_o, msg_kind_o}, snap);
    end
    chk("dropped_one", dropped_cnt_o, mdrop);
    chk("dropped_one_abs", dropped_cnt_o, 1);
    for (int i = 0; i < 300; i++) begin
      pulse(4'b0010, t);
      @(negedge clk);
    end
    chk("dropped_sat", dropped_cnt_o, 255);
    chk("dropped_model", dropped_cnt_o, mdrop);
    ack(0);
    expect_msg(1'b0, t);
    ack(0);
    repeat (5) @(negedge clk);
    chk("idle_after_drain", {busy_o, msg_valid_o}, 0);

    // out-of-range write
    wr(0, "Z");
    wr(40, 8'hAA);
    chk("overflow", overflow_o, 1);
    chk("overflow_model", overflow_o, movf);
    chk_mem("overflow_mem");

    // reset in the middle of SCAN
    for (int i = 0; i < 10; i++) wr(i, 8'(8'h41 + i));
    pulse(4'b0001, t);
    repeat (3) @(negedge clk);
    chk("busy_in_scan", busy_o, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_zero("mid_scan_reset");
    chk_mem("mid_scan_reset_mem");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (msg_valid_o || busy_o) seen++;
    end
    chk("no_msg_after_reset", seen, 0);

    // randomized strings, kinds and operands
    for (int r = 0; r < 25; r++) begin
      len = $urandom_range(0, MC);
      for (int i = 0; i < len; i++) wr(i, 8'($urandom_range(1, 255)));
      m = K'($urandom_range(1, 15));
      expected_i = $urandom;
      measured_i = $urandom;
      pulse(m, t);
      for (int k = 0; k < K; k++)
        if (m[k]) begin
          expect_msg((m & ((K'(1) << k) - K'(1))) == '0, t);
          ack($urandom_range(0, 3));
        end
    end
    chk("rand_dropped", dropped_cnt_o, mdrop);
    chk_mem("rand_mem");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
